// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit.
// A Moore FSM walks each instruction through FETCH/DECODE and an
// instruction-specific tail of 1-3 states, driving the shared-memory,
// single-ULA datapath. Unknown opcodes/functs trap to a sticky illegal
// flag; every non-trapped instruction that completes bumps a counter.
module multicycle_control_unit #(
    parameter int CNT_W  = 16,
    parameter bit EN_BNE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [2:0]       ULAControl,
    output logic [1:0]       PCSrc,
    output logic             Illegal,
    output logic             InstrDone,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    // Opcodes understood by DECODE.
    localparam logic [5:0] op_rtype = 6'b000000;
    localparam logic [5:0] op_j     = 6'b000010;
    localparam logic [5:0] op_beq   = 6'b000100;
    localparam logic [5:0] op_bne   = 6'b000101;
    localparam logic [5:0] op_addi  = 6'b001000;
    localparam logic [5:0] op_lw    = 6'b100011;
    localparam logic [5:0] op_sw    = 6'b101011;

    // R-type funct codes.
    localparam logic [5:0] fn_add = 6'b100000;
    localparam logic [5:0] fn_sub = 6'b100010;
    localparam logic [5:0] fn_and = 6'b100100;
    localparam logic [5:0] fn_or  = 6'b100101;
    localparam logic [5:0] fn_nor = 6'b100111;
    localparam logic [5:0] fn_slt = 6'b101010;

    // ULA operation codes.
    localparam logic [2:0] ula_add = 3'b010;
    localparam logic [2:0] ula_sub = 3'b110;
    localparam logic [2:0] ula_and = 3'b000;
    localparam logic [2:0] ula_or  = 3'b001;
    localparam logic [2:0] ula_nor = 3'b011;
    localparam logic [2:0] ula_slt = 3'b111;

    // ULA B-operand select.
    localparam logic [1:0] srcb_reg  = 2'b00;
    localparam logic [1:0] srcb_four = 2'b01;
    localparam logic [1:0] srcb_imm  = 2'b10;
    localparam logic [1:0] srcb_br   = 2'b11;

    // Next-PC select.
    localparam logic [1:0] pcsrc_result = 2'b00;
    localparam logic [1:0] pcsrc_out    = 2'b01;
    localparam logic [1:0] pcsrc_jump   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t           state;
    state_t           next_state;

    // Instruction attributes captured in DECODE so later states never look at OP.
    logic             is_sw;
    logic             is_bne;

    // Raw Moore decode, before reset gating of the strobes.
    logic             pcwrite_d;
    logic             irwrite_d;
    logic             regwrite_d;
    logic             memwrite_d;
    logic             branch_taken;
    logic [CNT_W-1:0] instr_count;
    logic             illegal;

    function automatic logic funct_legal(input logic [5:0] fn);
        return (fn == fn_add) || (fn == fn_sub) || (fn == fn_and) ||
               (fn == fn_or)  || (fn == fn_nor) || (fn == fn_slt);
    endfunction

    function automatic logic [2:0] funct_to_ula(input logic [5:0] fn);
        logic [2:0] code;
        code = ula_add;
        case (fn)
            fn_add:  code = ula_add;
            fn_sub:  code = ula_sub;
            fn_and:  code = ula_and;
            fn_or:   code = ula_or;
            fn_nor:  code = ula_nor;
            fn_slt:  code = ula_slt;
            default: code = ula_add;
        endcase
        return code;
    endfunction

    // State register; reset drops straight back to FETCH.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Latch lw/sw and beq/bne distinctions while the opcode is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_sw  <= 1'b0;
            is_bne <= 1'b0;
        end else if (state == DECODE) begin
            is_sw  <= (OP == op_sw);
            is_bne <= (OP == op_bne);
        end
    end

    // Next-state logic: DECODE dispatches, every final state returns to FETCH.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (OP)
                    op_lw, op_sw: next_state = MEMADR;
                    op_rtype:     next_state = funct_legal(Funct) ? EXEC : TRAP;
                    op_beq:       next_state = BRANCH;
                    op_bne:       next_state = EN_BNE ? BRANCH : TRAP;
                    op_addi:      next_state = ADDIEX;
                    op_j:         next_state = JUMP;
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR: next_state = is_sw ? MEMWR : MEMRD;
            MEMRD:  next_state = MEMWB;
            EXEC:   next_state = ALUWB;
            ADDIEX: next_state = ADDIWB;
            MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, TRAP: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Moore output decode per state; ULAControl idles at add.
    always_comb begin
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ULASrcA    = 1'b0;
        ULASrcB    = srcb_reg;
        ULAControl = ula_add;
        PCSrc      = pcsrc_result;
        pcwrite_d  = 1'b0;
        irwrite_d  = 1'b0;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        InstrDone  = 1'b0;
        case (state)
            FETCH: begin
                ULASrcB   = srcb_four;
                irwrite_d = 1'b1;
                pcwrite_d = 1'b1;
            end
            DECODE: begin
                ULASrcB = srcb_br;
            end
            MEMADR, ADDIEX: begin
                ULASrcA = 1'b1;
                ULASrcB = srcb_imm;
            end
            MEMRD: begin
                IorD = 1'b1;
            end
            MEMWB: begin
                regwrite_d = 1'b1;
                MemtoReg   = 1'b1;
                InstrDone  = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                memwrite_d = 1'b1;
                InstrDone  = 1'b1;
            end
            EXEC: begin
                ULASrcA    = 1'b1;
                ULASrcB    = srcb_reg;
                ULAControl = funct_to_ula(Funct);
            end
            ALUWB: begin
                regwrite_d = 1'b1;
                RegDst     = 1'b1;
                InstrDone  = 1'b1;
            end
            ADDIWB: begin
                regwrite_d = 1'b1;
                InstrDone  = 1'b1;
            end
            BRANCH: begin
                ULASrcA    = 1'b1;
                ULASrcB    = srcb_reg;
                ULAControl = ula_sub;
                PCSrc      = pcsrc_out;
                InstrDone  = 1'b1;
            end
            JUMP: begin
                PCSrc     = pcsrc_jump;
                pcwrite_d = 1'b1;
                InstrDone = 1'b1;
            end
            TRAP: begin
                InstrDone = 1'b1;
            end
            default: begin
                InstrDone = 1'b0;
            end
        endcase
    end

    // beq takes on Zero, bne on not-Zero; only meaningful while in BRANCH.
    assign branch_taken = (state == BRANCH) && (is_bne ? ~Zero : Zero);

    // Write strobes are held off for as long as reset is asserted.
    assign PCEn     = (pcwrite_d | branch_taken) & ~rst;
    assign IRWrite  = irwrite_d & ~rst;
    assign RegWrite = regwrite_d & ~rst;
    assign MemWrite = memwrite_d & ~rst;

    // Retired-instruction counter: bumps leaving any final state but TRAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (InstrDone && (state != TRAP)) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Sticky illegal flag, set on the edge leaving TRAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (state == TRAP) begin
            illegal <= 1'b1;
        end
    end

    assign InstrCount = instr_count;
    assign Illegal    = illegal;
    assign State      = state;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle successor to the single-cycle MIPS control decoder. A Moore FSM sequences each instruction over 3–5 clock cycles. It drives the shared-memory, single-ULA datapath (PC, IR, register file, ULA, memory) with per-state control signals. Unknown opcodes and funct codes are trapped through a sticky illegal flag, and retired instructions are counted.

## Interface
- CNT_W, 16: width of the retired-instruction counter.
- EN_BNE, 1: 1 decodes BNE (OP 000101); 0 treats it as illegal.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- OP  in  6  IR[31:26], stable from DECODE onward.
- Funct  in  6  IR[5:0].
- Zero  in  1  ULA zero flag, same cycle.
- PCEn  out  1  PC load enable (PCWrite | branch-taken).
- IorD  out  1  memory address select: 0 = PC, 1 = ULAOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load enable.
- RegDst  out  1  write register: 0 = rt, 1 = rd.
- MemtoReg  out  1  write data: 0 = ULAOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ULASrcA  out  1  ULA A: 0 = PC, 1 = register A.
- ULASrcB  out  2  ULA B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ULAControl  out  3  010 add, 110 sub, 000 and, 001 or, 011 nor, 111 slt.
- PCSrc  out  2  00 = ULAResult, 01 = ULAOut, 10 = jump target.
- Illegal  out  1  sticky; set by trap, cleared only by rst.
- InstrDone  out  1  one-cycle pulse in each instruction's final state.
- InstrCount  out  CNT_W  retired instructions, excluding trapped ones.
- State  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12. Codes 13–15 go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE.
  - DECODE dispatches on OP:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 → EXEC if Funct ∈ {100000, 100010, 100100, 100101, 100111, 101010}, else TRAP.
    - 000100, or 000101 with EN_BNE = 1 → BRANCH.
    - 001000 → ADDIEX.
    - 000010 → JUMP.
    - anything else → TRAP.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB.
  - EXEC → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, TRAP → FETCH.
- Outputs are Moore. Unlisted outputs are 0; ULAControl defaults to 010.
  - FETCH: IorD 0, ULASrcA 0, ULASrcB 01, PCSrc 00, IRWrite 1, PCWrite 1.
  - DECODE: ULASrcA 0, ULASrcB 11.
  - MEMADR, ADDIEX: ULASrcA 1, ULASrcB 10.
  - MEMRD: IorD 1.
  - MEMWB: RegWrite 1, MemtoReg 1, RegDst 0.
  - MEMWR: IorD 1, MemWrite 1.
  - EXEC: ULASrcA 1, ULASrcB 00, ULAControl decoded from Funct:
    - 100000 → 010, 100010 → 110, 100100 → 000.
    - 100101 → 001, 100111 → 011, 101010 → 111.
  - ALUWB: RegWrite 1, RegDst 1.
  - ADDIWB: RegWrite 1, RegDst 0.
  - BRANCH: ULASrcA 1, ULASrcB 00, ULAControl 110, PCSrc 01.
  - JUMP: PCSrc 10, PCWrite 1.
- PCEn = PCWrite | (BRANCH & OP == 000100 & Zero) | (BRANCH & OP == 000101 & ~Zero). Only the PCEn term depends on an input.
- InstrCount increments by 1 on the clock edge leaving any final state except TRAP. It wraps modulo 2^CNT_W.
- TRAP: sets Illegal on the exit edge and pulses InstrDone. The instruction is skipped and the PC is already PC+4.

## Timing
- Reset, asynchronous: State = FETCH, Illegal = 0, InstrCount = 0.
- While rst = 1, PCEn, IRWrite, RegWrite and MemWrite are forced to 0. The other outputs show FETCH decode.
- First FETCH strobes occur in the first cycle after rst deasserts.
- Latency in cycles:
  - lw 5.
  - sw, R-type, addi 4.
  - beq, bne, j 3.
  - trap 3.
- A reset asserted mid-instruction aborts immediately. No write strobe is issued after reset assertion.
- OP and Funct are sampled only in DECODE and EXEC. Changes in other states have no effect.

## Test plan
- Reset mid-MEMWR → MemWrite falls with rst; State = 0, InstrCount = 0, Illegal = 0.
- Sequence lw, sw, add (Funct 100000), addi, j → state traces:
  - lw: 0-1-2-3-4.
  - sw: 0-1-2-5.
  - add: 0-1-6-7.
  - addi: 0-1-9-10.
  - j: 0-1-11.
  - InstrCount = 5; ULAControl 010 in EXEC.
- beq with Zero = 1 → PCEn = 1 in BRANCH. With Zero = 0 → PCEn = 0.
- bne with EN_BNE = 1 → PCEn = ~Zero. With EN_BNE = 0 → TRAP.
- Each R funct (sub, and, or, nor, slt) → EXEC shows 110, 000, 001, 011, 111. Funct 000001 → TRAP.
- OP 111111 → TRAP, Illegal = 1 and held through subsequent instructions, InstrCount unchanged.
- CNT_W = 2 with 4 retired instructions → InstrCount wraps to 0.
